instruction_decode: RTL and testbench

Decode stage of the 5-stage RV32I pipeline, directly downstream of `instruction_fetch`. It registers the fetched instruction and PC and splits the instruction into register addresses, a sign-extended immediate, an ALU operation and an instruction class. It also detects load-use hazards and back-pressures fetch with a stall. Outputs feed the register-file read and execute stage one cycle after acceptance.

---
 rtl/rv32_pkg.sv | 83 ++++++++
 rtl/instruction_decode_if.sv | 37 +++
 rtl/decode_imm_gen.sv | 28 ++
 rtl/instruction_decode.sv | 143 ++++++++++++++
 tb/tb_instruction_decode.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, class bits
// and the decoded-instruction payload.
package rv32_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CLASS_W = 8;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    // Bit positions inside the one-hot class vector
    localparam int unsigned CLS_LOAD   = 0;
    localparam int unsigned CLS_STORE  = 1;
    localparam int unsigned CLS_BRANCH = 2;
    localparam int unsigned CLS_JAL    = 3;
    localparam int unsigned CLS_JALR   = 4;
    localparam int unsigned CLS_LUI    = 5;
    localparam int unsigned CLS_AUIPC  = 6;
    localparam int unsigned CLS_SYSTEM = 7;

    typedef struct packed {
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [31:0]        imm;
        logic [2:0]         funct3;
        alu_op_e            alu_op;
        logic [CLASS_W-1:0] cls;
        logic               illegal;
    } decode_t;

    // Formats carrying an rs2 field (R, S, B)
    function automatic logic has_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    // Base integer op from funct3; alt selects SUB/SRA where applicable
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch-to-decode and decode-to-execute signal bundle.
interface instruction_decode_if #(
    parameter int unsigned IWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32
);
    logic [IWIDTH-1:0]   d_i_instr;
    logic [PC_WIDTH-1:0] d_i_pc;
    logic                d_i_ce;
    logic                d_i_stall;
    logic                d_i_flush;
    logic [PC_WIDTH-1:0] d_o_pc;
    logic [IWIDTH-1:0]   d_o_instr;
    logic [4:0]          d_o_rs1_addr;
    logic [4:0]          d_o_rs2_addr;
    logic [4:0]          d_o_rd_addr;
    logic [31:0]         d_o_imm;
    logic [2:0]          d_o_funct3;
    logic [4:0]          d_o_alu_op;
    logic [7:0]          d_o_class;
    logic                d_o_illegal;
    logic                d_o_ce;
    logic                d_o_stall;

    modport master (
        output d_i_instr, d_i_pc, d_i_ce, d_i_stall, d_i_flush,
        input  d_o_pc, d_o_instr, d_o_rs1_addr, d_o_rs2_addr, d_o_rd_addr,
        input  d_o_imm, d_o_funct3, d_o_alu_op, d_o_class, d_o_illegal,
        input  d_o_ce, d_o_stall
    );

    modport slave (
        input  d_i_instr, d_i_pc, d_i_ce, d_i_stall, d_i_flush,
        output d_o_pc, d_o_instr, d_o_rs1_addr, d_o_rs2_addr, d_o_rd_addr,
        output d_o_imm, d_o_funct3, d_o_alu_op, d_o_class, d_o_illegal,
        output d_o_ce, d_o_stall
    );
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational immediate extraction for all RV32I formats.
module decode_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm_c
);

    // Pick the format from the opcode and sign-extend from bit 31
    always_comb begin
        imm_c = '0;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
                imm_c = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_c = {instr[31:12], 12'b0};
            OPC_JAL:
                imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm_c = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: registers the fetched instruction, splits it into
// fields/ALU op/class, and inserts a bubble on load-use hazards.
// Optional feature: define RV32M_DECODE_EN to decode the M extension.
module instruction_decode
    import rv32_pkg::*;
#(
    parameter int unsigned IWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                 f_clk,
    input  logic                 f_rst,
    instruction_decode_if.slave  bus
);

    logic [31:0] instr_c;
    logic [6:0]  opc_c;
    logic [2:0]  funct3_c;
    logic [6:0]  funct7_c;
    logic [31:0] imm_c;
    decode_t     dec_c;
    logic        hazard_c;

    assign instr_c  = 32'(bus.d_i_instr);
    assign opc_c    = instr_c[6:0];
    assign funct3_c = instr_c[14:12];
    assign funct7_c = instr_c[31:25];

    decode_imm_gen u_imm_gen (
        .instr (instr_c),
        .imm_c (imm_c)
    );

    // Field extraction, class, ALU op and legality of the incoming instruction
    always_comb begin
        dec_c         = '0;
        dec_c.rs1     = instr_c[19:15];
        dec_c.rs2     = instr_c[24:20];
        dec_c.rd      = instr_c[11:7];
        dec_c.imm     = imm_c;
        dec_c.funct3  = funct3_c;
        dec_c.alu_op  = ALU_ADD;
        dec_c.cls     = '0;
        dec_c.illegal = 1'b0;
        case (opc_c)
            OPC_LOAD:   dec_c.cls[CLS_LOAD] = 1'b1;
            OPC_STORE: begin
                dec_c.cls[CLS_STORE] = 1'b1;
                dec_c.rd             = '0;
            end
            OPC_BRANCH: begin
                dec_c.cls[CLS_BRANCH] = 1'b1;
                dec_c.rd              = '0;
                dec_c.alu_op          = ALU_SUB;
            end
            OPC_JAL:    dec_c.cls[CLS_JAL]    = 1'b1;
            OPC_JALR:   dec_c.cls[CLS_JALR]   = 1'b1;
            OPC_AUIPC:  dec_c.cls[CLS_AUIPC]  = 1'b1;
            OPC_SYSTEM: dec_c.cls[CLS_SYSTEM] = 1'b1;
            OPC_LUI: begin
                dec_c.cls[CLS_LUI] = 1'b1;
                dec_c.rs1          = '0;
            end
            OPC_OP_IMM: begin
                // Only the shifts interpret funct7; SLLI has no arithmetic variant
                if ((funct3_c == 3'b001) && (funct7_c == 7'h20)) begin
                    dec_c.illegal = 1'b1;
                end else begin
                    dec_c.alu_op = alu_from_funct3(funct3_c, funct7_c[5] && (funct3_c == 3'b101));
                end
            end
            OPC_OP: begin
                if (funct7_c == 7'h00) begin
                    dec_c.alu_op = alu_from_funct3(funct3_c, 1'b0);
                end else if (funct7_c == 7'h20) begin
                    if ((funct3_c == 3'b000) || (funct3_c == 3'b101)) begin
                        dec_c.alu_op = alu_from_funct3(funct3_c, 1'b1);
                    end else begin
                        dec_c.illegal = 1'b1;
                    end
                end
`ifdef RV32M_DECODE_EN
                else if (funct7_c == 7'h01) begin
                    dec_c.alu_op = alu_op_e'({2'b10, funct3_c});
                end
`endif
                else begin
                    dec_c.illegal = 1'b1;
                end
            end
            default:    dec_c.illegal = 1'b1;
        endcase
    end

    // Load in decode whose destination feeds the incoming instruction
    always_comb begin
        hazard_c = bus.d_o_ce
                 & bus.d_o_class[CLS_LOAD]
                 & (bus.d_o_rd_addr != 5'd0)
                 & bus.d_i_ce
                 & ((instr_c[19:15] == bus.d_o_rd_addr)
                    | (has_rs2(opc_c) & (instr_c[24:20] == bus.d_o_rd_addr)));
    end

    assign bus.d_o_stall = bus.d_i_stall | hazard_c;

    // Decode register: flush > stall > hazard bubble > accept > idle
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            bus.d_o_pc       <= '0;
            bus.d_o_instr    <= '0;
            bus.d_o_rs1_addr <= '0;
            bus.d_o_rs2_addr <= '0;
            bus.d_o_rd_addr  <= '0;
            bus.d_o_imm      <= '0;
            bus.d_o_funct3   <= '0;
            bus.d_o_alu_op   <= ALU_ADD;
            bus.d_o_class    <= '0;
            bus.d_o_illegal  <= 1'b0;
            bus.d_o_ce       <= 1'b0;
        end else if (bus.d_i_flush) begin
            bus.d_o_ce <= 1'b0;
        end else if (!bus.d_i_stall) begin
            if (hazard_c) begin
                bus.d_o_ce <= 1'b0;
            end else if (bus.d_i_ce) begin
                bus.d_o_pc       <= PC_WIDTH'(bus.d_i_pc);
                bus.d_o_instr    <= IWIDTH'(bus.d_i_instr);
                bus.d_o_rs1_addr <= dec_c.rs1;
                bus.d_o_rs2_addr <= dec_c.rs2;
                bus.d_o_rd_addr  <= dec_c.rd;
                bus.d_o_imm      <= dec_c.imm;
                bus.d_o_funct3   <= dec_c.funct3;
                bus.d_o_alu_op   <= dec_c.alu_op;
                bus.d_o_class    <= dec_c.cls;
                bus.d_o_illegal  <= dec_c.illegal;
                bus.d_o_ce       <= 1'b1;
            end else begin
                bus.d_o_ce <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_instruction_decode;

    logic f_clk = 1'b0;
    logic f_rst = 1'b0;

    always #5 f_clk = ~f_clk;

    instruction_decode_if #(.IWIDTH(32), .PC_WIDTH(32)) bus ();

    instruction_decode dut (
        .f_clk (f_clk),
        .f_rst (f_rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  alu;
        logic [2:0]  f3;
        logic [7:0]  cls;
        logic        ill;
        logic        ce;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t m;

    // funct3 -> ALU code for the plain (non-alternate) integer ops
    int unsigned alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    function automatic exp_t exp_reset();
        exp_t e;
        e.pc = 0; e.instr = 0; e.imm = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0;
        e.alu = 0; e.f3 = 0; e.cls = 0; e.ill = 0; e.ce = 0;
        return e;
    endfunction

    // Reference decode straight from the instruction-set rules
    function automatic exp_t decode_ref(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] ii, is, ib, iu, ij;
        logic legal;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'b0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e = exp_reset();
        e.pc = pc; e.instr = ins; e.ce = 1'b1; e.f3 = f3;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        case (op)
            7'h03: begin e.cls = 8'h01; e.imm = ii; end
            7'h23: begin e.cls = 8'h02; e.imm = is; e.rd = 0; end
            7'h63: begin e.cls = 8'h04; e.imm = ib; e.rd = 0; e.alu = 5'd1; end
            7'h6F: begin e.cls = 8'h08; e.imm = ij; end
            7'h67: begin e.cls = 8'h10; e.imm = ii; end
            7'h37: begin e.cls = 8'h20; e.imm = iu; e.rs1 = 0; end
            7'h17: begin e.cls = 8'h40; e.imm = iu; end
            7'h73: begin e.cls = 8'h80; e.imm = ii; end
            7'h13: begin
                e.imm = ii;
                if (f3 == 3'd1 && f7 == 7'h20) e.ill = 1'b1;
                else begin
                    e.alu = 5'(alu_tab[f3]);
                    if (f3 == 3'd5 && f7[5]) e.alu = 5'd7;
                end
            end
            7'h33: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                if (legal) begin
                    e.alu = 5'(alu_tab[f3]);
                    if (f7 == 7'h20) e.alu = (f3 == 3'd0) ? 5'd1 : 5'd7;
                end
`ifdef RV32M_DECODE_EN
                else if (f7 == 7'h01) begin
                    legal = 1'b1;
                    e.alu = 5'(16 + int'(f3));
                end
`endif
                e.ill = !legal;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic hazard_ref(input exp_t q, input logic ce, input logic [31:0] ins);
        logic uses_rs2;
        uses_rs2 = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
        return q.ce && q.cls[0] && (q.rd != 0) && ce &&
               ((ins[19:15] == q.rd) || (uses_rs2 && ins[24:20] == q.rd));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state advances on the same edges as the DUT
    always @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) m <= exp_reset();
        else if (bus.d_i_flush) m.ce <= 1'b0;
        else if (bus.d_i_stall) m <= m;
        else if (hazard_ref(m, bus.d_i_ce, bus.d_i_instr)) m.ce <= 1'b0;
        else if (bus.d_i_ce) m <= decode_ref(bus.d_i_instr, bus.d_i_pc);
        else m.ce <= 1'b0;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge f_clk) begin
        chk("pc",      bus.d_o_pc,               m.pc);
        chk("instr",   bus.d_o_instr,            m.instr);
        chk("rs1",     32'(bus.d_o_rs1_addr),    32'(m.rs1));
        chk("rs2",     32'(bus.d_o_rs2_addr),    32'(m.rs2));
        chk("rd",      32'(bus.d_o_rd_addr),     32'(m.rd));
        chk("imm",     bus.d_o_imm,              m.imm);
        chk("funct3",  32'(bus.d_o_funct3),      32'(m.f3));
        chk("alu_op",  32'(bus.d_o_alu_op),      32'(m.alu));
        chk("class",   32'(bus.d_o_class),       32'(m.cls));
        chk("illegal", 32'(bus.d_o_illegal),     32'(m.ill));
        chk("ce",      32'(bus.d_o_ce),          32'(m.ce));
        chk("stall",   32'(bus.d_o_stall),
            32'(bus.d_i_stall | hazard_ref(m, bus.d_i_ce, bus.d_i_instr)));
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic ce, input logic stall, input logic flush);
        bus.d_i_instr = ins;
        bus.d_i_pc    = pc;
        bus.d_i_ce    = ce;
        bus.d_i_stall = stall;
        bus.d_i_flush = flush;
    endtask

    task automatic tick();
        @(posedge f_clk);
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [6:0] f7s [4];
        int unsigned k;
        ins = $urandom;
        k = $urandom_range(0, 12);
        if (k < 10) ins[6:0] = ops[k];
        else if (k == 10) ins[6:0] = 7'h03;
        else if (k == 11) ins[6:0] = 7'h33;
        else ins[6:0] = 7'($urandom);
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'($urandom);
        if (ins[6:0] == 7'h33 || (ins[6:0] == 7'h13 && ins[13:12] == 2'b01))
            ins[31:25] = f7s[$urandom_range(0, 3)];
        return ins;
    endfunction

    exp_t pin;
    logic [31:0] cur_ins;

    initial begin
        m = exp_reset();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Hand-computed pins on the reference model itself
        pin = decode_ref(32'hFFB10093, 32'h0);
        chk("model_addi_imm", pin.imm, 32'hFFFFFFFB);
        pin = decode_ref(32'h00208463, 32'h0);
        chk("model_beq_imm", pin.imm, 32'h00000008);
        pin = decode_ref(32'hFFDFF0EF, 32'h0);
        chk("model_jal_imm", pin.imm, 32'hFFFFFFFC);
        pin = decode_ref(32'h0000A283, 32'h0);
        chk("model_lw_class", 32'(pin.cls), 32'h01);

        repeat (2) @(posedge f_clk);
        #2;
        chk("reset_ce",    32'(bus.d_o_ce),     32'h0);
        chk("reset_alu",   32'(bus.d_o_alu_op), 32'h0);
        chk("reset_pc",    bus.d_o_pc,          32'h0);
        chk("reset_stall", 32'(bus.d_o_stall),  32'h0);
        f_rst = 1'b1;

        // ADDI x1,x2,-5
        drive(32'hFFB10093, 32'h100, 1'b1, 1'b0, 1'b0);
        tick();
        chk("addi_rd",  32'(bus.d_o_rd_addr),  32'd1);
        chk("addi_rs1", 32'(bus.d_o_rs1_addr), 32'd2);
        chk("addi_imm", bus.d_o_imm,           32'hFFFFFFFB);
        chk("addi_alu", 32'(bus.d_o_alu_op),   32'd0);
        chk("addi_cls", 32'(bus.d_o_class),    32'd0);
        chk("addi_ce",  32'(bus.d_o_ce),       32'd1);
        chk("addi_ill", 32'(bus.d_o_illegal),  32'd0);

        // LW x5,0(x1) followed by dependent ADD x6,x5,x7
        drive(32'h0000A283, 32'h104, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h00728333, 32'h108, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall", 32'(bus.d_o_stall), 32'd1);
        tick();
        chk("lu_bubble_ce",  32'(bus.d_o_ce),    32'd0);
        chk("lu_stall_drop", 32'(bus.d_o_stall), 32'd0);
        tick();
        chk("lu_add_ce",  32'(bus.d_o_ce),       32'd1);
        chk("lu_add_rs1", 32'(bus.d_o_rs1_addr), 32'd5);
        chk("lu_add_rs2", 32'(bus.d_o_rs2_addr), 32'd7);
        chk("lu_add_rd",  32'(bus.d_o_rd_addr),  32'd6);

        // Downstream stall held for three cycles with ORI x4,x3,0x55 waiting
        drive(32'h0551E213, 32'h10C, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_instr", bus.d_o_instr,      32'h00728333);
            chk("stall_hold_ce",    32'(bus.d_o_ce),    32'd1);
            chk("stall_req",        32'(bus.d_o_stall), 32'd1);
        end
        drive(32'h0551E213, 32'h10C, 1'b1, 1'b0, 1'b0);
        tick();
        chk("stall_rel_instr", bus.d_o_instr,    32'h0551E213);
        chk("stall_rel_imm",   bus.d_o_imm,      32'h00000055);
        chk("stall_rel_alu",   32'(bus.d_o_alu_op), 32'd8);

        // BEQ in decode then flush together with stall
        drive(32'h00208463, 32'h110, 1'b1, 1'b0, 1'b0);
        tick();
        chk("beq_cls", 32'(bus.d_o_class),   32'h04);
        chk("beq_rd",  32'(bus.d_o_rd_addr), 32'd0);
        chk("beq_imm", bus.d_o_imm,          32'd8);
        chk("beq_alu", 32'(bus.d_o_alu_op),  32'd1);
        drive(32'hFFB10093, 32'h114, 1'b1, 1'b1, 1'b1);
        tick();
        chk("flush_ce",    32'(bus.d_o_ce), 32'd0);
        chk("flush_instr", bus.d_o_instr,   32'h00208463);

        // Unknown opcode
        drive(32'h0000007F, 32'h118, 1'b1, 1'b0, 1'b0);
        tick();
        chk("op7f_ill", 32'(bus.d_o_illegal), 32'd1);
        chk("op7f_ce",  32'(bus.d_o_ce),      32'd1);

        // MUL x3,x1,x2
        drive(32'h022081B3, 32'h11C, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef RV32M_DECODE_EN
        chk("mul_alu", 32'(bus.d_o_alu_op),  32'd16);
        chk("mul_ill", 32'(bus.d_o_illegal), 32'd0);
`else
        chk("mul_alu", 32'(bus.d_o_alu_op),  32'd0);
        chk("mul_ill", 32'(bus.d_o_illegal), 32'd1);
`endif

        // Randomized traffic
        cur_ins = rand_instr();
        for (int n = 0; n < 2000; n++) begin
            if (!(bus.d_o_stall && $urandom_range(0, 3) != 0)) cur_ins = rand_instr();
            drive(cur_ins, $urandom, ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
            tick();
            if (n == 1000) begin
                // Asynchronous reset mid-stream clears outputs without an edge
                f_rst = 1'b0;
                #1;
                chk("midrst_ce",    32'(bus.d_o_ce),     32'd0);
                chk("midrst_pc",    bus.d_o_pc,          32'd0);
                chk("midrst_instr", bus.d_o_instr,       32'd0);
                chk("midrst_class", 32'(bus.d_o_class),  32'd0);
                @(posedge f_clk);
                #2;
                f_rst = 1'b1;
            end
        end

        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
